// File: rtl/uart_rx_deframer_if.sv
// Receive-side bundle of the UART path: the serial pin and the deframed result
// that feeds the transmit stage.
`timescale 1ns/1ps
interface uart_rx_deframer_if;
   logic       rs232_rx;
   logic [7:0] rx_data;
   logic       rx_int;
   logic       frame_err;
   logic       busy;

   // master: the deframer (reads the pin, drives the result)
   modport master (input rs232_rx, output rx_data, rx_int, frame_err, busy);
   // slave: line driver / consumer of received bytes
   modport slave  (output rs232_rx, input rx_data, rx_int, frame_err, busy);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer: synchronises the serial pin, finds start bits,
// samples each bit at its centre with a baud counter and strobes out good bytes.
`timescale 1ns/1ps
module uart_rx_deframer #(
   parameter int BIT_DIV  = 217,
   parameter int HALF_DIV = BIT_DIV / 2
) (
   input logic                clk,
   input logic                rst_n,
   uart_rx_deframer_if.master bus
);

   typedef enum logic [2:0] {
      WAIT_HIGH = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } state_t;

   localparam logic [11:0] BIT_LAST  = 12'(BIT_DIV - 1);
   localparam logic [11:0] HALF_LAST = 12'(HALF_DIV - 1);

   logic        s1, s2, s3;
   logic        rxs;
   logic        fe;
   logic [1:0]  fill;
   state_t      state, state_nxt;
   logic [11:0] cnt;
   logic [2:0]  bidx;
   logic [7:0]  sr;
   logic [7:0]  rx_data_q;
   logic        rx_int_q;
   logic        frame_err_q;
   logic        start_hit, bit_hit;
   logic        smp_start, smp_data, smp_stop;
   logic        busy_c;

   assign rxs       = s2;
   assign fe        = s3 & ~s2;
   assign start_hit = (cnt == HALF_LAST);
   assign bit_hit   = (cnt == BIT_LAST);

   // Two-flop synchroniser plus a history flop for edge detection. The reset
   // value of 1 would fake a high line, so `fill` marks when s2 carries a real
   // pin sample; WAIT_HIGH only trusts rxs after that, which keeps a line held
   // low across reset from being taken as a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         s3   <= 1'b1;
         fill <= 2'b00;
      end else begin
         s1   <= bus.rs232_rx;
         s2   <= s1;
         s3   <= s2;
         fill <= {fill[0], 1'b1};
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_HIGH;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_HIGH: if (fill[1] && rxs) state_nxt = IDLE;
         IDLE:      if (fe) state_nxt = START;
         START:     if (start_hit) state_nxt = rxs ? IDLE : DATA;
         DATA:      if (bit_hit && bidx == 3'd7) state_nxt = STOP;
         STOP:      if (bit_hit) state_nxt = rxs ? IDLE : WAIT_HIGH;
         default:   state_nxt = WAIT_HIGH;
      endcase
   end

   // Output decode: busy flag and the per-state sample enables
   always_comb begin
      busy_c    = 1'b0;
      smp_start = 1'b0;
      smp_data  = 1'b0;
      smp_stop  = 1'b0;
      case (state)
         START: begin
            busy_c    = 1'b1;
            smp_start = start_hit;
         end
         DATA: begin
            busy_c    = 1'b1;
            smp_data  = bit_hit;
         end
         STOP: begin
            busy_c    = 1'b1;
            smp_stop  = bit_hit;
         end
         default: ;
      endcase
   end

   // Baud counter, bit index, result register and one-cycle strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 12'd0;
         bidx        <= 3'd0;
         rx_data_q   <= 8'h00;
         rx_int_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (!busy_c || smp_start || smp_data || smp_stop) cnt <= 12'd0;
         else                                              cnt <= cnt + 12'd1;
         if (smp_start)     bidx <= 3'd0;
         else if (smp_data) bidx <= bidx + 3'd1;
         rx_int_q    <= smp_stop & rxs;
         frame_err_q <= smp_stop & ~rxs;
         if (smp_stop && rxs) rx_data_q <= sr;
      end
   end

   // Data shift register, LSB first; contents only matter once a frame completes
   always_ff @(posedge clk) begin
      if (smp_data) sr <= {rxs, sr[7:1]};
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_int    = rx_int_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_c;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: a fast-baud instance (16/8) for the functional
// scenarios and a default-parameter instance for 115200-baud timing.
`timescale 1ns/1ps
module tb_uart_rx_deframer;
   localparam int B  = 16;
   localparam int H  = 8;
   localparam int DB = 217;
   localparam int DH = 108;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #20 clk = ~clk;

   uart_rx_deframer_if ua();
   uart_rx_deframer_if ub();

   uart_rx_deframer #(.BIT_DIV(B), .HALF_DIV(H)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ua));
   uart_rx_deframer dut_b (.clk(clk), .rst_n(rst_n), .bus(ub));

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // observed on dut_a: kind 0 = rx_int (data = rx_data), 1 = frame_err (data = rx_data held)
   int         obs_cyc[$];
   int         obs_kind[$];
   logic [7:0] obs_dat[$];
   int         exp_cyc[$];
   int         exp_kind[$];
   logic [7:0] exp_dat[$];
   int         busy_rise[$];
   int         busy_fall[$];
   int         both_cnt = 0;
   logic       busy_prev = 1'b0;
   logic [7:0] last_good = 8'h00;
   int         b_cyc[$];
   logic [7:0] b_dat[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ua.rx_int) begin
         obs_cyc.push_back(cyc); obs_kind.push_back(0); obs_dat.push_back(ua.rx_data);
      end
      if (ua.frame_err) begin
         obs_cyc.push_back(cyc); obs_kind.push_back(1); obs_dat.push_back(ua.rx_data);
      end
      if (ua.rx_int && ua.frame_err) both_cnt++;
      if (ua.busy && !busy_prev) busy_rise.push_back(cyc);
      if (!ua.busy && busy_prev) busy_fall.push_back(cyc);
      busy_prev = ua.busy;
      if (ub.rx_int) begin
         b_cyc.push_back(cyc); b_dat.push_back(ub.rx_data);
      end
   end

   task automatic hold(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic set_line(input int which, input logic v);
      if (which == 0) ua.rs232_rx = v;
      else            ub.rs232_rx = v;
   endtask

   task automatic clear_all();
      obs_cyc.delete(); obs_kind.delete(); obs_dat.delete();
      exp_cyc.delete(); exp_kind.delete(); exp_dat.delete();
      busy_rise.delete(); busy_fall.delete();
      b_cyc.delete(); b_dat.delete();
      both_cnt = 0;
   endtask

   // Sends one 8N1 frame and records what the receiver should report: the
   // result appears in the cycle after start-edge + 3 + HALF + 9 bit times.
   task automatic send(input int which, input logic [7:0] b, input logic stop, output int fall);
      int div, half;
      div  = (which == 0) ? B : DB;
      half = (which == 0) ? H : DH;
      fall = cyc;
      set_line(which, 1'b0); hold(div);
      for (int i = 0; i < 8; i++) begin
         set_line(which, b[i]); hold(div);
      end
      set_line(which, stop); hold(div);
      if (which == 0) begin
         exp_cyc.push_back(fall + 3 + half + 9 * div);
         exp_kind.push_back(stop ? 0 : 1);
         exp_dat.push_back(stop ? b : last_good);
         if (stop) last_good = b;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hold(3);
      @(negedge clk);
      vectors++;
      if ({ua.rx_data, ua.rx_int, ua.frame_err, ua.busy} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_a: got data %h int %b err %b busy %b, expected 00 0 0 0",
                  ua.rx_data, ua.rx_int, ua.frame_err, ua.busy);
      end
      vectors++;
      if ({ub.rx_data, ub.rx_int, ub.frame_err, ub.busy} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_b: got data %h int %b err %b busy %b, expected 00 0 0 0",
                  ub.rx_data, ub.rx_int, ub.frame_err, ub.busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      hold(8);
      vectors++;
      if (ua.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_busy: got %b, expected 0", ua.busy);
      end
      clear_all();
   endtask

   task automatic test_single_byte();
      int f;
      clear_all();
      send(0, 8'h55, 1'b1, f);
      hold(2 * B);
      vectors++;
      if (obs_cyc.size() !== exp_cyc.size()) begin
         miscompares++;
         $display("FAIL single_count: got %0d events, expected %0d", obs_cyc.size(), exp_cyc.size());
      end
      for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
         vectors++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i] || obs_dat[i] !== exp_dat[i]) begin
            miscompares++;
            $display("FAIL single_evt%0d: got cyc %0d kind %0d data %h, expected cyc %0d kind %0d data %h",
                     i, obs_cyc[i], obs_kind[i], obs_dat[i], exp_cyc[i], exp_kind[i], exp_dat[i]);
         end
      end
      vectors++;
      if (busy_rise.size() !== 1 || busy_fall.size() !== 1) begin
         miscompares++;
         $display("FAIL single_busy_edges: got %0d rises %0d falls, expected 1 1", busy_rise.size(), busy_fall.size());
      end else begin
         vectors++;
         if (busy_rise[0] !== f + 3 || busy_fall[0] - busy_rise[0] !== 152) begin
            miscompares++;
            $display("FAIL single_busy_window: got rise %0d len %0d, expected rise %0d len 152",
                     busy_rise[0], busy_fall[0] - busy_rise[0], f + 3);
         end
      end
   endtask

   task automatic test_back_to_back();
      int f0, f1;
      clear_all();
      send(0, 8'hA3, 1'b1, f0);
      send(0, 8'h0F, 1'b1, f1);
      hold(2 * B);
      vectors++;
      if (obs_cyc.size() !== 2) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d events, expected 2", obs_cyc.size());
      end else begin
         vectors++;
         if (obs_cyc[1] - obs_cyc[0] !== 160) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles, expected 160", obs_cyc[1] - obs_cyc[0]);
         end
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i] || obs_dat[i] !== exp_dat[i]) begin
               miscompares++;
               $display("FAIL b2b_evt%0d: got cyc %0d kind %0d data %h, expected cyc %0d kind %0d data %h",
                        i, obs_cyc[i], obs_kind[i], obs_dat[i], exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
         end
      end
   endtask

   task automatic test_glitch();
      int f;
      clear_all();
      f = cyc;
      ua.rs232_rx = 1'b0; hold(3);
      ua.rs232_rx = 1'b1; hold(3 * B);
      vectors++;
      if (obs_cyc.size() !== 0) begin
         miscompares++;
         $display("FAIL glitch_strobe: got %0d events, expected 0", obs_cyc.size());
      end
      vectors++;
      if (busy_rise.size() !== 1 || busy_fall.size() !== 1) begin
         miscompares++;
         $display("FAIL glitch_busy_edges: got %0d rises %0d falls, expected 1 1", busy_rise.size(), busy_fall.size());
      end else begin
         vectors++;
         if (busy_rise[0] !== f + 3 || busy_fall[0] - busy_rise[0] !== 8) begin
            miscompares++;
            $display("FAIL glitch_busy_window: got rise %0d len %0d, expected rise %0d len 8",
                     busy_rise[0], busy_fall[0] - busy_rise[0], f + 3);
         end
      end
      clear_all();
      send(0, 8'h3C, 1'b1, f);
      hold(2 * B);
      vectors++;
      if (obs_cyc.size() !== 1 || obs_cyc[0] !== exp_cyc[0] || obs_kind[0] !== 0 || obs_dat[0] !== 8'h3C) begin
         miscompares++;
         $display("FAIL glitch_follow: got %0d events (first data %h), expected 1 event data 3c at cyc %0d",
                  obs_cyc.size(), (obs_dat.size() > 0) ? obs_dat[0] : 8'hxx, exp_cyc[0]);
      end
   endtask

   task automatic test_framing_error();
      int f;
      clear_all();
      send(0, 8'h00, 1'b0, f);
      hold(20 * B);
      vectors++;
      if (obs_cyc.size() !== 1) begin
         miscompares++;
         $display("FAIL ferr_count: got %0d events, expected 1", obs_cyc.size());
      end else begin
         vectors++;
         if (obs_cyc[0] !== exp_cyc[0] || obs_kind[0] !== 1 || obs_dat[0] !== exp_dat[0]) begin
            miscompares++;
            $display("FAIL ferr_evt: got cyc %0d kind %0d data %h, expected cyc %0d kind 1 data %h",
                     obs_cyc[0], obs_kind[0], obs_dat[0], exp_cyc[0], exp_dat[0]);
         end
      end
      vectors++;
      if (busy_rise.size() !== 1 || ua.busy !== 1'b0 || ua.rx_data !== 8'h3C) begin
         miscompares++;
         $display("FAIL ferr_break: got %0d busy rises busy %b data %h, expected 1 rise busy 0 data 3c",
                  busy_rise.size(), ua.busy, ua.rx_data);
      end
      ua.rs232_rx = 1'b1; hold(2 * B);
      clear_all();
      send(0, 8'h81, 1'b1, f);
      hold(2 * B);
      vectors++;
      if (obs_cyc.size() !== 1 || obs_cyc[0] !== exp_cyc[0] || obs_kind[0] !== 0 || obs_dat[0] !== 8'h81) begin
         miscompares++;
         $display("FAIL ferr_recover: got %0d events (first data %h), expected 1 event data 81 at cyc %0d",
                  obs_cyc.size(), (obs_dat.size() > 0) ? obs_dat[0] : 8'hxx, exp_cyc[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int f;
      logic [7:0] ff_byte;
      ff_byte = 8'hFF;
      clear_all();
      ua.rs232_rx = 1'b0; hold(B);
      for (int i = 0; i < 3; i++) begin
         ua.rs232_rx = ff_byte[i]; hold(B);
      end
      ua.rs232_rx = ff_byte[3]; hold(B / 2);
      ua.rs232_rx = 1'b0;
      rst_n = 1'b0;
      hold(2);
      @(negedge clk);
      vectors++;
      if ({ua.rx_data, ua.rx_int, ua.frame_err, ua.busy} !== 11'h000) begin
         miscompares++;
         $display("FAIL midrst_outputs: got data %h int %b err %b busy %b, expected 00 0 0 0",
                  ua.rx_data, ua.rx_int, ua.frame_err, ua.busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_good = 8'h00;
      clear_all();
      hold(5 * B);
      vectors++;
      if (obs_cyc.size() !== 0 || busy_rise.size() !== 0) begin
         miscompares++;
         $display("FAIL midrst_low_line: got %0d events %0d busy rises, expected 0 0",
                  obs_cyc.size(), busy_rise.size());
      end
      ua.rs232_rx = 1'b1; hold(2 * B);
      send(0, 8'h42, 1'b1, f);
      hold(2 * B);
      vectors++;
      if (obs_cyc.size() !== 1 || obs_cyc[0] !== exp_cyc[0] || obs_kind[0] !== 0 || obs_dat[0] !== 8'h42) begin
         miscompares++;
         $display("FAIL midrst_follow: got %0d events (first data %h), expected 1 event data 42 at cyc %0d",
                  obs_cyc.size(), (obs_dat.size() > 0) ? obs_dat[0] : 8'hxx, exp_cyc[0]);
      end
   endtask

   task automatic test_random_frames();
      int f, gap;
      logic [7:0] b;
      logic stop;
      clear_all();
      for (int n = 0; n < 12; n++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         send(0, b, stop, f);
         gap = $urandom_range(stop ? 0 : 1, 24);
         ua.rs232_rx = 1'b1; hold(gap);
      end
      hold(2 * B);
      vectors++;
      if (obs_cyc.size() !== exp_cyc.size()) begin
         miscompares++;
         $display("FAIL rand_count: got %0d events, expected %0d", obs_cyc.size(), exp_cyc.size());
      end
      for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
         vectors++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i] || obs_dat[i] !== exp_dat[i]) begin
            miscompares++;
            $display("FAIL rand_evt%0d: got cyc %0d kind %0d data %h, expected cyc %0d kind %0d data %h",
                     i, obs_cyc[i], obs_kind[i], obs_dat[i], exp_cyc[i], exp_kind[i], exp_dat[i]);
         end
      end
      vectors++;
      if (ua.rx_data !== last_good || both_cnt !== 0) begin
         miscompares++;
         $display("FAIL rand_final: got data %h overlaps %0d, expected data %h overlaps 0",
                  ua.rx_data, both_cnt, last_good);
      end
   endtask

   task automatic test_default_baud();
      int f;
      clear_all();
      send(1, 8'h5A, 1'b1, f);
      hold(DB);
      vectors++;
      if (b_cyc.size() !== 1) begin
         miscompares++;
         $display("FAIL default_count: got %0d strobes, expected 1", b_cyc.size());
      end else begin
         vectors++;
         if (b_cyc[0] !== f + 3 + 108 + 1953 || b_dat[0] !== 8'h5A) begin
            miscompares++;
            $display("FAIL default_evt: got cyc %0d data %h, expected cyc %0d data 5a",
                     b_cyc[0], b_dat[0], f + 3 + 108 + 1953);
         end
      end
   endtask

   initial begin
      ua.rs232_rx = 1'b1;
      ub.rs232_rx = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_framing_error();
      test_reset_mid_frame();
      test_random_frames();
      test_default_baud();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

- Serial receive front end of the CPLD UART path.
- Synchronises the asynchronous `rs232_rx` pin and detects start bits.
- Samples each bit at its centre using an internal baud counter, and deframes 8N1 characters.
- Presents each good byte on `rx_data` with a one-cycle `rx_int` strobe, which the transmit stage loads directly (`rx_data`/`rx_int` connect straight to its inputs).

## Interface
- `BIT_DIV`, default 217: clk cycles per bit (25 MHz / 115200). Legal range 8..4095.
- `HALF_DIV`, default `BIT_DIV/2` (108): cycles from start-edge detection to the start-bit centre sample.
- `clk` input, 1 bit: system clock, 25 MHz.
- `rst_n` input, 1 bit: asynchronous, active-low reset. Clock is `clk`.
- `rs232_rx` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, 8 bits: last correctly received byte. Holds until the next good frame.
- `rx_int` output, 1 bit: one-cycle strobe; `rx_data` is valid and new in the same cycle.
- `frame_err` output, 1 bit: one-cycle strobe; the stop bit was sampled low.
- `busy` output, 1 bit: high while a frame is being received (states START, DATA, STOP).

## Operation
- **Synchroniser:** `s1 <= rs232_rx`, `s2 <= s1`, `s3 <= s2`, all reset to 1. The line value `rxs` is `s2`. Falling edge `fe = s3 & ~s2`.
- **Bit counter:** 12-bit counter `cnt`.
- **Bit index:** 3-bit `bidx`.
- **Shift register:** 8-bit, LSB first; `sr <= {rxs, sr[7:1]}` on each data sample.
- **States:**
  - WAIT_HIGH: reset state. Go to IDLE on the first cycle where `rxs==1`.
  - IDLE: on `fe`, `cnt <= 0` and go to START. The edge of this transition is T0.
  - START: when `cnt==HALF_DIV-1`, sample `rxs`:
    - `rxs==1`: false start. Go to IDLE with no strobe.
    - `rxs==0`: `cnt <= 0`, `bidx <= 0`, go to DATA.
  - DATA: when `cnt==BIT_DIV-1`, shift in `rxs` and set `cnt <= 0`. After `bidx==7`, go to STOP; otherwise `bidx++`.
  - STOP: when `cnt==BIT_DIV-1`, sample `rxs`:
    - `rxs==1`: `rx_data <= sr`, `rx_int <= 1`, go to IDLE.
    - `rxs==0`: `frame_err <= 1`, `rx_data` unchanged, go to WAIT_HIGH (break/line-low protection).
- **Counter:** `cnt` increments every cycle outside IDLE/WAIT_HIGH and resets to 0 on each sample. It never wraps within the legal `BIT_DIV` range.
- **Strobes:** `rx_int` and `frame_err` are registered and cleared on the following cycle. They are never high together.
- **Overrun:** no flow control and no overrun detection. The consumer must take `rx_data` on `rx_int`.
- **Line falls during WAIT_HIGH:** no start is accepted until the line has first been seen high.

## Timing
- **Reset values:** `rx_data=8'h00`, `rx_int=0`, `frame_err=0`, `busy=0`, state WAIT_HIGH, `s1..s3=1`.
- **Reset mid-frame:** the frame is aborted with no strobe. The block waits for line high before accepting a start, so a line held low across reset is never read as a start.
- **Start detection:** T0 is the second clock edge after the first edge that registers the pin low into `s1`.
- **Sample points:**
  - Start bit: T0 + `HALF_DIV`.
  - Data bit i (0..7): T0 + `HALF_DIV` + (i+1)·`BIT_DIV`.
  - Stop bit: T0 + `HALF_DIV` + 9·`BIT_DIV`.
- **Result latency:** `rx_int`/`frame_err` and `rx_data` update on the stop-sample edge and are high for exactly the following cycle.
- **`busy` window:** rises on T0. Falls on the false-start edge or on the stop-sample edge.
- **Back-to-back frames:** the state is IDLE from the stop-sample edge onward. A next start edge one cycle later is accepted, so back-to-back frames with one stop bit work.
- **Glitch rejection:** a low pulse shorter than `HALF_DIV` cycles produces no strobe and returns to IDLE.

## Test plan
- **Single byte:** `BIT_DIV=16`, `HALF_DIV=8`, send 0x55 8N1 → exactly one `rx_int` pulse at T0+8+144, with `rx_data=8'h55`, `frame_err` never high, `busy` high from T0 for 152 cycles.
- **Back-to-back:** 0xA3 then 0x0F with no idle gap → two `rx_int` pulses 160 cycles apart; `rx_data` reads 0xA3 then 0x0F.
- **Glitch:** line low for 3 cycles, then high → no strobes; `busy` high for 8 cycles, then IDLE. A following 0x3C frame is received correctly.
- **Framing error / break:** 0x00 with stop bit 0, line then held low for 20 bit times → one `frame_err` pulse, no `rx_int`, `rx_data` unchanged. No further activity until the line goes high, after which 0x81 is received.
- **Reset mid-frame:** `rst_n` pulsed low during bit 3 of 0xFF with the line low at release → all outputs reset, no strobe. The next clean 0x42 is received.
- **Defaults:** `BIT_DIV=217`, send 0x5A at 115200-baud timing → `rx_int` with `rx_data=8'h5A` at T0+108+1953.
